speed_calc: RTL and testbench

- Downstream consumer of the quadrature speed-measurement stage.
- Takes the averaged edge-period count (in_period, clock ticks) and rotation direction, samples them on a fixed internal timebase, and converts period to speed with a sequential restoring divider: speed = DIVIDEND / period.
- Produces a signed, saturated speed word with a one-cycle valid strobe for the control loop.

---
 rtl/speed_pkg.sv | 24 ++
 rtl/speed_calc_if.sv | 37 +++
 rtl/speed_calc_divider.sv | 80 ++++++++
 rtl/speed_calc.sv | 139 +++++++++++++
 tb/tb_speed_calc.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/speed_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : speed_pkg                                                  |
// | Purpose : Shared widths, default scale constant and FSM state        |
// |           encoding for the speed_calc block and its divider.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package speed_pkg;

  localparam int PERIOD_W   = 31;
  localparam int DIVIDEND_W = 32;

  // K = f_clk * 60 / PPR for 100 MHz and 1024 PPR; speed comes out in RPM.
  localparam logic [DIVIDEND_W-1:0] DEFAULT_DIVIDEND = 32'd5859375;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    DONE  = 2'd2,
    DONE0 = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/speed_calc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : speed_calc_if                                            |
// | Purpose   : Groups the upstream period/direction inputs and the      |
// |             speed result outputs of speed_calc.                      |
// | Signals   : in_en, in_period[30:0], in_dir    (producer -> block)    |
// |             out_speed[OUT_W-1:0], out_valid, out_busy, out_sat,      |
// |             out_stop                          (block -> consumer)    |
// | Modports  : master = environment side, slave = speed_calc side       |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface speed_calc_if #(
  parameter int OUT_W = 16
);
  import speed_pkg::*;

  logic                 in_en;
  logic [PERIOD_W-1:0]  in_period;
  logic                 in_dir;
  logic [OUT_W-1:0]     out_speed;
  logic                 out_valid;
  logic                 out_busy;
  logic                 out_sat;
  logic                 out_stop;

  modport master (
    output in_en, in_period, in_dir,
    input  out_speed, out_valid, out_busy, out_sat, out_stop
  );

  modport slave (
    input  in_en, in_period, in_dir,
    output out_speed, out_valid, out_busy, out_sat, out_stop
  );

endinterface
`default_nettype wire

// File: rtl/speed_calc_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : seq_divider                                                |
// | Purpose : 32-step restoring unsigned divider, one quotient bit per   |
// |           clock, MSB first.                                          |
// | Ports   : in_clk, in_rst (async, active-low)                         |
// |           start    - load dividend, begin a division                 |
// |           dividend - 32-bit numerator, captured on start             |
// |           divisor  - 31-bit denominator, must stay stable while busy |
// |           busy     - division in progress                            |
// |           done     - high during the final step                      |
// |           quotient - final quotient, valid while done is high        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module seq_divider
  import speed_pkg::*;
(
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [PERIOD_W-1:0]   divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  logic [DIVIDEND_W-1:0] rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic [DIVIDEND_W-1:0] rem_sh;
  logic                  ge;

  always_comb begin
    // The divisor is below 2^31, so the remainder never needs its MSB and
    // the 32-bit shift cannot lose information.
    rem_sh = {rem_q[DIVIDEND_W-2:0], quo_q[DIVIDEND_W-1]};
    ge     = (rem_sh >= {1'b0, divisor});
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      cnt_d  = 5'd31;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? (rem_sh - {1'b0, divisor}) : rem_sh;
      quo_d = {quo_q[DIVIDEND_W-2:0], ge};
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd0) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == 5'd0);
  // Exposing the post-step value lets the consumer register the result on
  // the same edge that retires the last quotient bit.
  assign quotient = quo_d;

endmodule
`default_nettype wire

// File: rtl/speed_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : speed_calc                                                 |
// | Purpose : Samples the averaged edge period on a fixed timebase and   |
// |           converts it to a signed, saturated speed DIVIDEND/period.  |
// | Ports   : in_clk  - system clock                                     |
// |           in_rst  - asynchronous active-low reset                    |
// |           bus     - speed_calc_if.slave (enable, period, direction   |
// |                     in; speed, valid, busy, sat, stop out)           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module speed_calc
  import speed_pkg::*;
#(
  parameter logic [DIVIDEND_W-1:0] DIVIDEND   = DEFAULT_DIVIDEND,
  parameter int                    SAMPLE_DIV = 100000,
  parameter int                    OUT_W      = 16
) (
  input  logic         in_clk,
  input  logic         in_rst,
  speed_calc_if.slave  bus
);

  localparam logic [23:0]           TICK_AT = 24'(SAMPLE_DIV - 1);
  localparam logic [DIVIDEND_W-1:0] MAX_MAG = DIVIDEND_W'((64'd1 << (OUT_W - 1)) - 64'd1);

  state_e               state_q, state_d;
  logic [23:0]          tmr_q, tmr_d;
  logic [PERIOD_W-1:0]  p_q, p_d;
  logic                 dir_q, dir_d;
  logic [OUT_W-1:0]     speed_q, speed_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;
  logic                 stop_q, stop_d;
  logic                 tick;
  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [DIVIDEND_W-1:0] div_quo;
  logic                 over;
  logic [OUT_W-1:0]     mag;

  // Timebase: free-running while enabled, parked at 0 otherwise.
  assign tick = bus.in_en && (tmr_q == TICK_AT);

  always_comb begin
    tmr_d = '0;
    if (bus.in_en && !tick) begin
      tmr_d = tmr_q + 24'd1;
    end
  end

  seq_divider u_div (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (p_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Clip before negation so the most negative code is never produced.
  assign over = (div_quo > MAX_MAG);
  assign mag  = over ? MAX_MAG[OUT_W-1:0] : div_quo[OUT_W-1:0];

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    dir_d     = dir_q;
    speed_d   = speed_q;
    sat_d     = sat_q;
    stop_d    = stop_q;
    valid_d   = 1'b0;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ticks seen in any other state are simply dropped.
        if (tick) begin
          p_d   = bus.in_period;
          dir_d = bus.in_dir;
          if (bus.in_period == '0) begin
            state_d = DONE0;
            speed_d = '0;
            sat_d   = 1'b0;
            stop_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d   = DIV;
            div_start = 1'b1;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = DONE;
          speed_d = dir_q ? mag : (OUT_W'(0) - mag);
          sat_d   = over;
          stop_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      DONE0:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      p_q     <= '0;
      dir_q   <= 1'b0;
      speed_q <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      p_q     <= p_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      stop_q  <= stop_d;
    end
  end

  assign bus.out_speed = speed_q;
  assign bus.out_valid = valid_q;
  assign bus.out_busy  = div_busy;
  assign bus.out_sat   = sat_q;
  assign bus.out_stop  = stop_q;

endmodule
`default_nettype wire

// File: tb/tb_speed_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_speed_calc                                              |
// | Purpose : Self-checking bench for speed_calc: directed vector table, |
// |           randomized samples against a reference model, and control  |
// |           sequences (reset, enable drop, input change mid-division). |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_speed_calc;
  import speed_pkg::*;

  localparam int     SAMPLE_DIV = 40;
  localparam int     OUT_W      = 16;
  localparam longint K          = 5859375;
  localparam longint MAXV       = 32767;

  typedef struct {
    string       name;
    logic [30:0] p;
    logic        d;
    logic [15:0] sp;
    logic        sat;
    logic        stop;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   prev_lat;

  always #5 clk = ~clk;

  speed_calc_if #(.OUT_W(OUT_W)) bus ();

  speed_calc #(
    .DIVIDEND   (32'd5859375),
    .SAMPLE_DIV (SAMPLE_DIV),
    .OUT_W      (OUT_W)
  ) dut (
    .in_clk (clk),
    .in_rst (rst_n),
    .bus    (bus.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: floor division, clip magnitude, then apply sign.
  function automatic void model(input logic [30:0] p, input logic d,
                                output logic [15:0] sp, output logic sat, output logic stop);
    longint q;
    if (p == 31'd0) begin
      sp = 16'd0; sat = 1'b0; stop = 1'b1;
    end else begin
      q    = K / longint'(p);
      stop = 1'b0;
      sat  = (q > MAXV);
      if (sat) q = MAXV;
      sp = d ? 16'(q) : 16'(-q);
    end
  endfunction

  // Cycles from the sampling tick to the result strobe.
  function automatic int lat(input logic [30:0] p);
    return (p == 31'd0) ? 1 : 33;
  endfunction

  task automatic wait_valid(input int bound, output int n, output bit busy_seen, output bit ok);
    n = 0; busy_seen = 0; ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.out_busy) busy_seen = 1;
      if (bus.out_valid) ok = 1;
    end
  endtask

  task automatic wait_busy(input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.out_busy) seen = 1;
    end
    check({name, "_busy_timeout"}, 64'(seen), 64'd1);
  endtask

  // Waits for the next strobe, compares it, then confirms the strobe is a
  // single cycle wide. exp_n < 0 skips the interval check.
  task automatic expect_result(input string name, input logic [15:0] sp, input logic sat,
                               input logic stop, input int exp_n);
    int n; bit bs; bit ok;
    wait_valid(400, n, bs, ok);
    check({name, "_valid_timeout"}, 64'(ok), 64'd1);
    if (ok) begin
      if (exp_n >= 0) check({name, "_interval"}, 64'(n), 64'(exp_n));
      check({name, "_speed"}, 64'(bus.out_speed), 64'(sp));
      check({name, "_sat"},   64'(bus.out_sat),   64'(sat));
      check({name, "_stop"},  64'(bus.out_stop),  64'(stop));
      check({name, "_busy_seen"}, 64'(bs), 64'(!stop));
      @(posedge clk); #1;
      check({name, "_one_cycle"}, 64'(bus.out_valid), 64'd0);
      check({name, "_hold"}, 64'(bus.out_speed), 64'(sp));
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_speed"}, 64'(bus.out_speed), 64'd0);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_busy"},  64'(bus.out_busy),  64'd0);
    check({name, "_sat"},   64'(bus.out_sat),   64'd0);
    check({name, "_stop"},  64'(bus.out_stop),  64'd0);
  endtask

  initial begin
    vec_t        vecs[10];
    logic [30:0] p;
    logic        d;
    logic [15:0] sp;
    logic        sat;
    logic        stop;
    int          n;
    bit          bs;
    bit          ok;

    vecs[0] = '{"fwd_1000",   31'd5859,       1'b1, 16'h03E8, 1'b0, 1'b0};
    vecs[1] = '{"rev_1000",   31'd5859,       1'b0, 16'hFC18, 1'b0, 1'b0};
    vecs[2] = '{"stopped",    31'd0,          1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{"sat_fwd",    31'd1,          1'b1, 16'h7FFF, 1'b1, 1'b0};
    vecs[4] = '{"sat_rev",    31'd1,          1'b0, 16'h8001, 1'b1, 1'b0};
    vecs[5] = '{"max_period", 31'h7FFFFFFF,   1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{"exact_32",   31'd183105,     1'b1, 16'h0020, 1'b0, 1'b0};
    vecs[7] = '{"edge_nosat", 31'd179,        1'b0, 16'h8023, 1'b0, 1'b0};
    vecs[8] = '{"edge_sat",   31'd178,        1'b0, 16'h8001, 1'b1, 1'b0};
    vecs[9] = '{"stop_rev",   31'd0,          1'b0, 16'h0000, 1'b0, 1'b1};

    bus.in_en = 1'b0; bus.in_period = '0; bus.in_dir = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;

    // Disabled: no ticks at all
    wait_valid(100, n, bs, ok);
    check("disabled_no_valid", 64'(ok), 64'd0);

    // First sample latency from enable
    bus.in_period = 31'd5859; bus.in_dir = 1'b1; bus.in_en = 1'b1;
    expect_result("first_latency", 16'h03E8, 1'b0, 1'b0, SAMPLE_DIV + 32);
    prev_lat = 33;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      bus.in_period = vecs[i].p; bus.in_dir = vecs[i].d;
      expect_result(vecs[i].name, vecs[i].sp, vecs[i].sat, vecs[i].stop,
                    SAMPLE_DIV + lat(vecs[i].p) - prev_lat - 1);
      prev_lat = lat(vecs[i].p);
    end

    // Randomized samples against the reference model
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       p = 31'($urandom_range(1, 400));
        1:       p = 31'($urandom_range(400, 200000));
        2:       p = 31'($urandom);
        default: p = ($urandom_range(0, 1) == 0) ? 31'd0 : 31'($urandom_range(176, 182));
      endcase
      d = 1'($urandom_range(0, 1));
      model(p, d, sp, sat, stop);
      bus.in_period = p; bus.in_dir = d;
      expect_result("random", sp, sat, stop, SAMPLE_DIV + lat(p) - prev_lat - 1);
      prev_lat = lat(p);
    end

    // Inputs changing mid-division must not disturb the latched sample
    bus.in_period = 31'd5859; bus.in_dir = 1'b1;
    wait_busy("midchange");
    repeat (5) @(posedge clk);
    #1 bus.in_period = 31'd1; bus.in_dir = 1'b0;
    expect_result("midchange_latched", 16'h03E8, 1'b0, 1'b0, -1);
    expect_result("midchange_next", 16'h8001, 1'b1, 1'b0, -1);

    // Reset in the middle of a division
    bus.in_period = 31'd5859; bus.in_dir = 1'b0;
    wait_busy("midreset");
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset_async");
    wait_valid(3, n, bs, ok);
    check("midreset_no_valid", 64'(ok), 64'd0);
    rst_n = 1'b1;
    expect_result("after_reset", 16'hFC18, 1'b0, 1'b0, SAMPLE_DIV + 32);

    // Enable dropped mid-division: this result completes, then silence
    wait_busy("endrop");
    repeat (4) @(posedge clk);
    #1 bus.in_en = 1'b0;
    expect_result("endrop_final", 16'hFC18, 1'b0, 1'b0, -1);
    wait_valid(3 * SAMPLE_DIV, n, bs, ok);
    check("endrop_no_more_valid", 64'(ok), 64'd0);
    check("endrop_outputs_hold", 64'(bus.out_speed), 64'hFC18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
